// File: rtl/versa_meta_regs_pkg.sv
// Shared definitions for the VERSA metadata register block: window defaults,
// FSM encoding and register offsets.
package versa_meta_regs_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] META_MIN_DEF  = 16'h0140;
    localparam logic [DATA_W-1:0] META_SIZE_DEF = 16'h0004;

    localparam logic [DATA_W-1:0] ER_MIN_OFS = 16'd0;
    localparam logic [DATA_W-1:0] ER_MAX_OFS = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DONE   = 2'b10
    } er_state_e;

endpackage

// File: rtl/versa_meta_regs.sv
// Memory-mapped ER_min/ER_max bounds for the VERSA monitor; bounds lock while
// the CPU executes inside the executable region.
module versa_meta_regs
    import versa_meta_regs_pkg::*;
#(
    parameter logic [DATA_W-1:0] META_MIN  = META_MIN_DEF,
    parameter logic [DATA_W-1:0] META_SIZE = META_SIZE_DEF
) (
    input  logic              clk,
    input  logic              puc,
    input  logic [DATA_W-1:0] pc,
    input  logic              data_en,
    input  logic              data_wr,
    input  logic [DATA_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_din,
    output logic [DATA_W-1:0] data_dout,
    output logic [DATA_W-1:0] ER_min,
    output logic [DATA_W-1:0] ER_max,
    output logic              er_valid,
    output logic              er_active,
    output logic              er_done,
    output logic              wr_violation
);

    localparam int unsigned ADDR_XW = DATA_W + 1;

    er_state_e state_q;
    er_state_e state_d;

    logic               hit;
    logic               wr_hit;
    logic               rd_hit;
    logic               sel_max;
    logic [ADDR_XW-1:0] win_end;
    logic               reg_wr_c;
    logic               viol_c;

    // Window end computed one bit wider so a window touching 0xFFFF cannot wrap.
    assign win_end = ADDR_XW'(META_MIN) + ADDR_XW'(META_SIZE);
    assign hit     = data_en && (data_addr >= META_MIN)
                     && (ADDR_XW'(data_addr) < win_end);
    assign wr_hit  = hit && data_wr;
    assign rd_hit  = hit && !data_wr;
    assign sel_max = (data_addr[1] == ER_MAX_OFS[1]);

    assign er_valid  = (ER_min < ER_max) && !ER_min[0] && !ER_max[0];
    assign er_active = (state_q == ST_ACTIVE);
    assign er_done   = (state_q == ST_DONE);

    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A same-cycle write wins; entry is retried against the new bounds.
                if ((pc == ER_min) && er_valid && !wr_hit) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (pc == ER_max) begin
                    state_d = ST_DONE;
                end else if ((pc < ER_min) || (pc > ER_max)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_wr_c = 1'b0;
        viol_c   = 1'b0;
        if (wr_hit) begin
            if (state_q == ST_IDLE) begin
                reg_wr_c = 1'b1;
            end else begin
                viol_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            ER_min       <= '0;
            ER_max       <= '0;
            data_dout    <= '0;
            wr_violation <= 1'b0;
        end else begin
            wr_violation <= viol_c;
            if (reg_wr_c && !sel_max) begin
                ER_min <= data_din;
            end
            if (reg_wr_c && sel_max) begin
                ER_max <= data_din;
            end
            if (rd_hit) begin
                data_dout <= sel_max ? ER_max : ER_min;
            end else begin
                data_dout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_versa_meta_regs.sv
// Directed bench for versa_meta_regs: per-cycle comparison against a
// behavioural model plus literal expectations at key points.
module tb_versa_meta_regs;

    logic        clk = 1'b0;
    logic        puc;
    logic [15:0] pc;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic [15:0] data_dout;
    logic [15:0] ER_min;
    logic [15:0] ER_max;
    logic        er_valid;
    logic        er_active;
    logic        er_done;
    logic        wr_violation;

    int n_total = 0;
    int n_pass  = 0;
    bit running = 1'b0;

    // Model state
    logic [15:0] m_min, m_max, m_dout;
    bit          m_in_er, m_done, m_viol;

    versa_meta_regs dut (
        .clk(clk), .puc(puc), .pc(pc), .data_en(data_en), .data_wr(data_wr),
        .data_addr(data_addr), .data_din(data_din), .data_dout(data_dout),
        .ER_min(ER_min), .ER_max(ER_max), .er_valid(er_valid),
        .er_active(er_active), .er_done(er_done), .wr_violation(wr_violation)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_valid();
        return (m_min < m_max) && (m_min % 2 == 0) && (m_max % 2 == 0);
    endfunction

    // Model: what the outputs must be after each edge, from the block's rules.
    always @(posedge clk or posedge puc) begin
        if (puc) begin
            m_min = 0; m_max = 0; m_dout = 0;
            m_in_er = 0; m_done = 0; m_viol = 0;
        end else begin
            bit in_win, wr, rd, locked, next_in, next_done;
            in_win = data_en && data_addr >= 16'h0140 && data_addr <= 16'h0143;
            wr     = in_win && data_wr;
            rd     = in_win && !data_wr;
            locked = m_in_er || m_done;
            next_in   = 0;
            next_done = 0;
            if (m_in_er) begin
                if (pc == m_max) next_done = 1;
                else next_in = (pc >= m_min) && (pc <= m_max);
            end else if (!m_done) begin
                next_in = (pc == m_min) && m_valid() && !wr;
            end
            m_viol = wr && locked;
            m_dout = !rd ? 16'h0 : (data_addr[1] ? m_max : m_min);
            if (wr && !locked) begin
                if (data_addr[1]) m_max = data_din;
                else m_min = data_din;
            end
            m_in_er = next_in;
            m_done  = next_done;
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (running) begin
            check("ER_min",       ER_min,               m_min);
            check("ER_max",       ER_max,               m_max);
            check("er_valid",     16'(er_valid),        16'(m_valid()));
            check("er_active",    16'(er_active),       16'(m_in_er));
            check("er_done",      16'(er_done),         16'(m_done));
            check("wr_violation", 16'(wr_violation),    16'(m_viol));
            check("data_dout",    data_dout,            m_dout);
        end
    end

    // One cycle of stimulus; returns just after the sampling edge.
    task automatic step(input logic [15:0] p, input bit en, input bit wr,
                        input logic [15:0] a, input logic [15:0] d);
        pc = p; data_en = en; data_wr = wr; data_addr = a; data_din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] p);
        step(p, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_min"},    ER_min,                0);
        check({tag, "_max"},    ER_max,                0);
        check({tag, "_dout"},   data_dout,             0);
        check({tag, "_flags"},  16'({er_valid, er_active, er_done, wr_violation}), 0);
    endtask

    initial begin
        puc = 1'b1;
        pc = 0; data_en = 0; data_wr = 0; data_addr = 0; data_din = 0;
        @(posedge clk); #1;
        all_zero("reset");
        running = 1'b1;
        @(posedge clk); #1;
        puc = 1'b0;

        // Configure and read back
        step(16'h0000, 1, 1, 16'h0140, 16'hE000);
        check("cfg_min", ER_min, 16'hE000);
        step(16'h0000, 1, 1, 16'h0142, 16'hE0FE);
        check("cfg_max", ER_max, 16'hE0FE);
        check("cfg_valid", 16'(er_valid), 1);
        step(16'h0000, 1, 0, 16'h0142, 16'h0);
        check("rd_max", data_dout, 16'hE0FE);
        step(16'h0000, 1, 0, 16'h0141, 16'h0);
        check("rd_min_odd", data_dout, 16'hE000);
        step(16'h0000, 1, 0, 16'h0144, 16'h0);
        check("rd_outside", data_dout, 16'h0);
        step(16'h0000, 1, 1, 16'h013E, 16'h7777);
        idle(16'h0000);

        // Execute, with locked writes along the way
        idle(16'hE000);
        check("enter", 16'(er_active), 1);
        idle(16'hE002);
        step(16'hE004, 1, 1, 16'h0140, 16'h1234);
        check("lock_min", ER_min, 16'hE000);
        check("lock_viol", 16'(wr_violation), 1);
        step(16'hE006, 1, 1, 16'h0142, 16'h1111);
        step(16'hE008, 1, 1, 16'h0140, 16'h2222);
        check("b2b_viol", 16'(wr_violation), 1);
        idle(16'hE00A);
        check("viol_clear", 16'(wr_violation), 0);
        idle(16'hE0FE);
        check("exit_done", 16'(er_done), 1);
        check("exit_active", 16'(er_active), 0);
        step(16'hE100, 1, 1, 16'h0140, 16'h5555);
        check("done_viol", 16'(wr_violation), 1);
        check("done_pulse", 16'(er_done), 0);
        check("done_min", ER_min, 16'hE000);
        idle(16'h0000);

        // Leaving the region early drops back to idle without a done pulse
        idle(16'hE000);
        idle(16'h1000);
        check("escape", 16'({er_active, er_done}), 0);

        // Simultaneous write and entry: write wins
        step(16'hE000, 1, 1, 16'h0140, 16'hE100);
        check("simul_min", ER_min, 16'hE100);
        check("simul_idle", 16'(er_active), 0);
        check("simul_invalid", 16'(er_valid), 0);
        idle(16'hE100);
        check("invalid_noenter", 16'(er_active), 0);

        // Swapped and odd bounds
        step(16'h0, 1, 1, 16'h0140, 16'hE0FE);
        step(16'h0, 1, 1, 16'h0142, 16'hE000);
        idle(16'hE0FE);
        check("swapped_noenter", 16'(er_active), 0);
        step(16'h0, 1, 1, 16'h0140, 16'hE001);
        step(16'h0, 1, 1, 16'h0142, 16'hE0FE);
        check("odd_invalid", 16'(er_valid), 0);
        idle(16'hE001);
        check("odd_noenter", 16'(er_active), 0);

        // Asynchronous reset in the middle of an ER execution
        step(16'h0, 1, 1, 16'h0140, 16'hE000);
        idle(16'hE000);
        check("pre_rst_active", 16'(er_active), 1);
        #2 puc = 1'b1;
        #1;
        all_zero("async_rst");
        @(posedge clk); #1;
        check("rst_no_done", 16'(er_done), 0);
        puc = 1'b0;
        idle(16'hE000);
        idle(16'h0000);

        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/versa_meta_regs.md
# versa_meta_regs

Memory-mapped metadata register block holding the executable-region bounds (ER_min, ER_max) consumed by the VERSA hardware monitor. It sits directly upstream of the monitor on the data bus and drives its ER_min/ER_max inputs. It tracks whether the CPU is inside a protected ER execution and locks the bounds for the duration of that execution. Writes attempted while locked are rejected and flagged.

## Interface
Parameters:
- META_MIN, 16'h0140, word address of ER_min; ER_max is at META_MIN+2
- META_SIZE, 16'h0004, decoded window size in bytes

Ports:
- clk  in  1  system clock
- puc  in  1  asynchronous, active-high reset
- pc  in  16  current program counter
- data_en  in  1  data bus access strobe
- data_wr  in  1  1 = write, 0 = read (qualified by data_en)
- data_addr  in  16  byte address
- data_din  in  16  write data
- data_dout  out  16  read data, registered
- ER_min  out  16  registered ER lower bound
- ER_max  out  16  registered ER upper bound (last instruction address)
- er_valid  out  1  bounds well-formed
- er_active  out  1  ER execution in progress (bounds locked)
- er_done  out  1  one-cycle pulse on ER exit at ER_max
- wr_violation  out  1  one-cycle pulse on a rejected write

## Operation
- Decode: hit = data_en & (data_addr >= META_MIN) & (data_addr < META_MIN+META_SIZE); register select = data_addr[1]; data_addr[0] ignored; word access only.
- er_valid = (ER_min < ER_max) & ~ER_min[0] & ~ER_max[0]; 16-bit unsigned compare; combinational from the registers.
- FSM states:
  - IDLE: writes accepted. Go to ACTIVE when pc == ER_min, er_valid = 1, and no write hit occurs this cycle.
  - ACTIVE: writes rejected. Go to DONE when pc == ER_max. Go to IDLE when pc is outside [ER_min, ER_max]; the downstream monitor resets in that case.
  - DONE: held for one cycle, then IDLE. Writes are rejected in DONE.
- er_active = (state == ACTIVE); er_done = (state == DONE).
- Write hit in IDLE: the selected register takes data_din at the clock edge. A write in the same cycle as pc == ER_min wins; entry is re-evaluated next cycle against the new bounds.
- Write hit in ACTIVE or DONE: registers unchanged; wr_violation = 1 in the following cycle.
- Read hit (data_wr = 0): data_dout = selected register in the following cycle. Otherwise data_dout = 0 the following cycle.

## Timing
- Reset (puc high, async): ER_min = 0x0000, ER_max = 0x0000, state IDLE, data_dout = 0, wr_violation = 0. All outputs are therefore 0 and er_valid = 0.
- Write-to-output latency: 1 cycle; ER_min/ER_max update at the edge that samples the write.
- Read latency: 1 cycle.
- Entry: pc == ER_min at edge N → er_active high after edge N.
- Exit: pc == ER_max sampled while ACTIVE → er_done high for exactly 1 cycle, er_active low in that same cycle.
- er_valid dropping is impossible while ACTIVE, because writes are blocked.
- puc asserted mid-ACTIVE: immediate return to IDLE with bounds cleared; no er_done pulse.
- Back-to-back rejected writes: wr_violation stays high for each cycle that follows a rejected write.

## Structure
- Shared package: META_MIN/META_SIZE defaults, FSM state encoding (IDLE=2'b00, ACTIVE=2'b01, DONE=2'b10), register offsets (ER_MIN_OFS=0, ER_MAX_OFS=2).
- Single module. The address decode and bound compare stay inline; no sub-module is warranted.
- Instantiated beside VERSA; its ER_min/ER_max outputs feed the monitor directly.

## Test plan
- Reset: assert puc mid-operation → all outputs 0, er_valid 0 within the same cycle (async).
- Configure: write 0xE000 to 0x0140, then 0xE0FE to 0x0142 → ER_min = 0xE000 and ER_max = 0xE0FE one cycle after each write; er_valid = 1; read of 0x0142 returns 0xE0FE one cycle later.
- Execute: pc = 0xE000 → er_active = 1 next cycle; pc walks to 0xE0FE → er_done 1-cycle pulse, then IDLE.
- Locked write: while ACTIVE, write 0x1234 to 0x0140 → ER_min stays 0xE000; wr_violation pulses 1 cycle.
- Invalid bounds: ER_min = 0xE0FE, ER_max = 0xE000 (or an odd ER_min of 0xE001) → er_valid = 0; pc = ER_min does not enter ACTIVE.
- Simultaneous write and entry: in IDLE, write ER_min = 0xE100 in the cycle pc == 0xE000 → ER_min = 0xE100, state stays IDLE.
